// File: rtl/lfsr_decrypt_engine.sv
// -----------------------------------------------------------------------------
// lfsr_decrypt_engine
//
// Purpose:
//   Recovers a message that was XOR-encrypted with an LFSR key stream.  The
//   engine reads a ciphertext block from SRC_BASE and finds which candidate
//   tap pattern produced it. Any candidate is tested against the known all-zero
//   preamble (key == ciphertext there).  It then decrypts the rest of the block,
//   drops the leading zero plaintext bytes and writes the remaining bytes to
//   DST_BASE.  The destination block is then padded with zeros up to MSG_LEN
//   bytes.
//
// Ports:
//   Clk       in   clock, everything on the rising edge
//   Reset     in   synchronous active-high reset
//   Start     in   high holds the engine idle; a run launches when it falls
//   Ack       out  run complete (held until the next run launches)
//   rd_addr   out  memory read address (data returns one cycle later)
//   rd_data   in   read data, MSB is the parity bit
//   wr_en     out  write strobe, one byte per cycle
//   wr_addr   out  write address
//   wr_data   out  write data
//   ptrn_idx  out  index of the tap pattern that validated
//   no_match  out  no tap pattern validated
//
// Configuration macro:
//   PARITY_CHECK_EN  when defined, a source byte with bad parity is written
//                    as 8'h80 instead of its plaintext.
// -----------------------------------------------------------------------------
module lfsr_decrypt_engine #(
  parameter int LFSR_W    = 7,
  parameter int NUM_PTRN  = 9,
  parameter logic [NUM_PTRN*LFSR_W-1:0] PTRN_TABLE =
    {7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B},
  parameter int MSG_LEN   = 64,
  parameter int SRC_BASE  = 64,
  parameter int DST_BASE  = 0,
  parameter int CHECK_LEN = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic [7:0]        rd_addr,
  input  logic [LFSR_W:0]   rd_data,
  output logic              wr_en,
  output logic [7:0]        wr_addr,
  output logic [LFSR_W:0]   wr_data,
  output logic [3:0]        ptrn_idx,
  output logic              no_match
);

`ifdef PARITY_CHECK_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  localparam logic [7:0] SRC_BASE_B = 8'(SRC_BASE);
  localparam logic [7:0] DST_BASE_B = 8'(DST_BASE);
  localparam logic [7:0] MSG_LEN_B  = 8'(MSG_LEN);
  localparam logic [7:0] LAST_IDX   = 8'(MSG_LEN - 1);
  localparam logic [7:0] CHECK_LAST = 8'(CHECK_LEN - 1);
  localparam logic [3:0] LAST_PTRN  = 4'(NUM_PTRN - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    SKIP   = 3'd2,
    EMIT   = 3'd3,
    FILL   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // One LFSR advance: shift left, feed back the parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                   input logic [LFSR_W-1:0] tap);
    return {s[LFSR_W-2:0], ^(s & tap)};
  endfunction

  // Tap pattern p; entry 0 sits in the most significant slot of the table.
  function automatic logic [LFSR_W-1:0] tap_of(input logic [3:0] p);
    return PTRN_TABLE[(NUM_PTRN - 1 - int'(p)) * LFSR_W +: LFSR_W];
  endfunction

  // High when the stored parity bit disagrees with the data bits.
  function automatic logic parity_err(input logic [LFSR_W:0] b);
    return b[LFSR_W] ^ (^b[LFSR_W-1:0]);
  endfunction

  state_t              state_r;
  logic                start_d_r;
  logic                live_r;      // rd_addr holds a read whose data is wanted
  logic [7:0]          rd_idx_r;    // source index currently on rd_addr
  logic                tag_vld_r;   // rd_data this cycle belongs to the stream
  logic [7:0]          tag_idx_r;   // source index of rd_data this cycle
  logic [3:0]          ptrn_r;
  logic [LFSR_W-1:0]   init_r;
  logic [LFSR_W-1:0]   key_r;       // key for the byte on rd_data
  logic [7:0]          out_n_r;     // destination offset of the next write

  logic [3:0]          next_ptrn_s;
  logic [LFSR_W-1:0]   cur_tap_s;
  logic [LFSR_W-1:0]   next_tap_s;
  logic [LFSR_W-1:0]   data_s;
  logic [LFSR_W:0]     plain_s;
  logic                flag_s;
  logic [LFSR_W:0]     out_byte_s;
  logic                last_s;

  // Decode of the current read byte: plaintext, parity flag and output byte.
  always_comb begin
    if (ptrn_r == LAST_PTRN) begin
      next_ptrn_s = 4'd0;
    end else begin
      next_ptrn_s = ptrn_r + 4'd1;
    end
    cur_tap_s  = tap_of(ptrn_r);
    next_tap_s = tap_of(next_ptrn_s);
    data_s     = rd_data[LFSR_W-1:0];
    plain_s    = {1'b0, data_s ^ key_r};
    flag_s     = PARITY_EN & parity_err(rd_data);
    if (flag_s) begin
      out_byte_s = {1'b1, {LFSR_W{1'b0}}};
    end else begin
      out_byte_s = plain_s;
    end
    last_s = (tag_idx_r == LAST_IDX);
  end

  // Control FSM, read pipeline and all registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= IDLE;
      Ack       <= 1'b0;
      wr_en     <= 1'b0;
      rd_addr   <= SRC_BASE_B;
      wr_addr   <= DST_BASE_B;
      wr_data   <= {(LFSR_W+1){1'b0}};
      ptrn_idx  <= 4'd0;
      no_match  <= 1'b0;
      start_d_r <= 1'b0;
      live_r    <= 1'b0;
      rd_idx_r  <= 8'd0;
      tag_vld_r <= 1'b0;
      tag_idx_r <= 8'd0;
      ptrn_r    <= 4'd0;
      init_r    <= {LFSR_W{1'b0}};
      key_r     <= {LFSR_W{1'b0}};
      out_n_r   <= 8'd0;
    end else begin
      start_d_r <= Start;
      wr_en     <= 1'b0;

      // Free-running read stream; rd_data lags rd_addr by one cycle, so the
      // tag registers move in step with the memory's output register.
      tag_vld_r <= live_r && (rd_idx_r < MSG_LEN_B);
      tag_idx_r <= rd_idx_r;
      if (live_r && (rd_idx_r < MSG_LEN_B)) begin
        rd_idx_r <= rd_idx_r + 8'd1;
        if (rd_idx_r < LAST_IDX) begin
          rd_addr <= rd_addr + 8'd1;
        end
      end

      case (state_r)
        IDLE: begin
          if (start_d_r && !Start) begin
            state_r   <= SEARCH;
            Ack       <= 1'b0;
            ptrn_idx  <= 4'd0;
            no_match  <= 1'b0;
            ptrn_r    <= 4'd0;
            out_n_r   <= 8'd0;
            live_r    <= 1'b1;
            rd_idx_r  <= 8'd0;
            rd_addr   <= SRC_BASE_B;
            tag_vld_r <= 1'b0;
          end
        end

        SEARCH: begin
          if (tag_vld_r) begin
            if (tag_idx_r == 8'd0) begin
              init_r <= data_s;
              key_r  <= lfsr_step(data_s, cur_tap_s);
            end else if (data_s == key_r) begin
              key_r <= lfsr_step(key_r, cur_tap_s);
              if (tag_idx_r == CHECK_LAST) begin
                ptrn_idx <= ptrn_r;
                state_r  <= SKIP;
              end
            end else if (ptrn_r == LAST_PTRN) begin
              no_match  <= 1'b1;
              live_r    <= 1'b0;
              tag_vld_r <= 1'b0;
              state_r   <= DONE;
            end else begin
              // Rewind to byte 1 for the next pattern and drop the read that
              // is already in flight.
              ptrn_r    <= next_ptrn_s;
              key_r     <= lfsr_step(init_r, next_tap_s);
              rd_idx_r  <= 8'd1;
              rd_addr   <= SRC_BASE_B + 8'd1;
              tag_vld_r <= 1'b0;
            end
          end
        end

        SKIP: begin
          if (tag_vld_r) begin
            key_r <= lfsr_step(key_r, cur_tap_s);
            if (out_byte_s != {(LFSR_W+1){1'b0}}) begin
              wr_en   <= 1'b1;
              wr_addr <= DST_BASE_B + out_n_r;
              wr_data <= out_byte_s;
              out_n_r <= out_n_r + 8'd1;
              state_r <= last_s ? FILL : EMIT;
            end else if (last_s) begin
              state_r <= FILL;
            end
            if (last_s) begin
              live_r <= 1'b0;
            end
          end
        end

        EMIT: begin
          if (tag_vld_r) begin
            key_r   <= lfsr_step(key_r, cur_tap_s);
            wr_en   <= 1'b1;
            wr_addr <= DST_BASE_B + out_n_r;
            wr_data <= out_byte_s;
            out_n_r <= out_n_r + 8'd1;
            if (last_s) begin
              live_r  <= 1'b0;
              state_r <= FILL;
            end
          end
        end

        FILL: begin
          if (out_n_r < MSG_LEN_B) begin
            wr_en   <= 1'b1;
            wr_addr <= DST_BASE_B + out_n_r;
            wr_data <= {(LFSR_W+1){1'b0}};
            out_n_r <= out_n_r + 8'd1;
            if (out_n_r == LAST_IDX) begin
              state_r <= DONE;
            end
          end else begin
            state_r <= DONE;
          end
        end

        DONE: begin
          Ack    <= 1'b1;
          live_r <= 1'b0;
          if (!start_d_r && Start) begin
            state_r <= IDLE;
          end
        end

        default: begin
          state_r <= IDLE;
          live_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
`timescale 1ns/1ps
module tb_lfsr_decrypt_engine;

  localparam int LW        = 7;
  localparam int MSG_LEN   = 64;
  localparam int SRC_BASE  = 64;
  localparam int DST_BASE  = 0;
  localparam int CHECK_LEN = 8;
  localparam int RUN_BUDGET = 1000;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic [7:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] ptrn_idx;
  logic       no_match;

  lfsr_decrypt_engine dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Ack      (Ack),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ptrn_idx (ptrn_idx),
    .no_match (no_match)
  );

  always #5 Clk = ~Clk;

  // source memory (written by stimulus only), registered read port
  logic [7:0] mem [0:255];
  always @(posedge Clk) rd_data <= mem[rd_addr];

  // destination image, written only by the write monitor
  logic [7:0] dst_mem [0:255];

  int total = 0;
  int bad   = 0;
  int wr_count = 0;
  logic [15:0] exp_q [$];

  logic [6:0] taps [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  string msgs [3] = '{"  f        A joke is a very serious thing.", "Hi there LFSR", ""};

  typedef struct {
    string      name;
    int         tap_sel;
    logic [6:0] init;
    int         pre_len;
    int         msg_sel;
    int         corrupt;
    bit         raw55;
    int         exp_ptrn;
    bit         exp_nm;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  // scoreboard: every DUT write is matched against the oldest expected write
  always @(negedge Clk) begin
    if (wr_en) begin
      logic [15:0] e;
      wr_count++;
      dst_mem[wr_addr] = wr_data;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=0x%0h data=0x%0h with nothing expected", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("write", {wr_addr, wr_data}, e);
      end
    end
  end

  // Encrypt the vector into source memory and queue the expected writes.
  task automatic setup(input vec_t v);
    logic [6:0] pt [MSG_LEN];
    logic [6:0] key;
    logic [6:0] c;
    logic [7:0] b;
    logic [7:0] val;
    string      m;
    bit         skipping;
    int         n;
    exp_q.delete();
    m = msgs[v.msg_sel];
    for (int i = 0; i < MSG_LEN; i++) pt[i] = 7'h00;
    for (int k = 0; k < m.len(); k++) begin
      if (v.pre_len + k < MSG_LEN) pt[v.pre_len + k] = 7'(m[k] - 8'h20);
    end
    key = v.init;
    for (int i = 0; i < MSG_LEN; i++) begin
      c = pt[i] ^ key;
      mem[SRC_BASE + i] = {^c, c};
      key = step(key, taps[v.tap_sel]);
    end
    if (v.corrupt >= 0) begin
      b = mem[SRC_BASE + v.corrupt];
      b[2] = ~b[2];
      mem[SRC_BASE + v.corrupt] = b;
    end
    if (v.raw55) begin
      for (int i = 0; i < MSG_LEN; i++) mem[SRC_BASE + i] = 8'h55;
    end else begin
      n = 0;
      skipping = 1'b1;
      for (int i = CHECK_LEN; i < MSG_LEN; i++) begin
        val = {1'b0, pt[i]};
        if (i == v.corrupt) begin
`ifdef PARITY_CHECK_EN
          val = 8'h80;
`else
          val = val ^ 8'h04;
`endif
        end
        if (!(skipping && val == 8'h00)) begin
          skipping = 1'b0;
          exp_q.push_back({8'(DST_BASE + n), val});
          n++;
        end
      end
      for (int j = n; j < MSG_LEN; j++) exp_q.push_back({8'(DST_BASE + j), 8'h00});
    end
  endtask

  task automatic launch;
    Start = 1'b1;
    tick;
    tick;
    Start = 1'b0;
    tick;
  endtask

  task automatic run_vec(input vec_t v);
    bit         done;
    logic       prev_we;
    logic [7:0] prev_wa;
    setup(v);
    wr_count = 0;
    launch;
    check({v.name, ":ack_low_after_launch"}, Ack, 0);
    done = 1'b0;
    prev_we = 1'b0;
    prev_wa = 8'h00;
    for (int c = 0; c < RUN_BUDGET && !done; c++) begin
      prev_we = wr_en;
      prev_wa = wr_addr;
      tick;
      if (Ack) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s:timeout Ack=%0d expected 1 within %0d cycles", v.name, Ack, RUN_BUDGET);
    end
    @(negedge Clk);
    #1;
    check({v.name, ":ptrn_idx"}, ptrn_idx, v.exp_ptrn);
    check({v.name, ":no_match"}, no_match, v.exp_nm);
    check({v.name, ":pending_writes"}, exp_q.size(), 0);
    check({v.name, ":write_count"}, wr_count, v.exp_nm ? 0 : MSG_LEN);
    if (!v.exp_nm) begin
      check({v.name, ":ack_after_final_write_en"}, prev_we, 1);
      check({v.name, ":ack_after_final_write_addr"}, prev_wa, DST_BASE + MSG_LEN - 1);
    end
  endtask

  initial begin
    int         seen;
    int         cnt_before;
    bit         hold_ok;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      dst_mem[i] = 8'hFF;
    end

    vecs[0] = '{name:"joke",      tap_sel:8, init:7'h01, pre_len:10, msg_sel:0, corrupt:-1, raw55:1'b0, exp_ptrn:8, exp_nm:1'b0};
    vecs[1] = '{name:"joke_par",  tap_sel:8, init:7'h01, pre_len:10, msg_sel:0, corrupt:40, raw55:1'b0, exp_ptrn:8, exp_nm:1'b0};
    vecs[2] = '{name:"tap60",     tap_sel:0, init:7'h7F, pre_len:8,  msg_sel:1, corrupt:-1, raw55:1'b0, exp_ptrn:0, exp_nm:1'b0};
    vecs[3] = '{name:"nomatch",   tap_sel:0, init:7'h00, pre_len:8,  msg_sel:2, corrupt:-1, raw55:1'b1, exp_ptrn:0, exp_nm:1'b1};
    vecs[4] = '{name:"allzero",   tap_sel:8, init:7'h01, pre_len:10, msg_sel:2, corrupt:-1, raw55:1'b0, exp_ptrn:8, exp_nm:1'b0};

    // reset state
    Reset = 1'b1;
    Start = 1'b0;
    tick;
    tick;
    tick;
    check("rst:Ack", Ack, 0);
    check("rst:wr_en", wr_en, 0);
    check("rst:rd_addr", rd_addr, SRC_BASE);
    check("rst:wr_addr", wr_addr, DST_BASE);
    check("rst:wr_data", wr_data, 0);
    check("rst:ptrn_idx", ptrn_idx, 0);
    check("rst:no_match", no_match, 0);
    Reset = 1'b0;
    tick;

    for (int t = 0; t < 5; t++) begin
      run_vec(vecs[t]);
      check({vecs[t].name, ":ack_high"}, Ack, 1);
      if (t == 0) begin
        check("joke:dst0", dst_mem[DST_BASE], 8'h46);
        for (int k = 1; k <= 8; k++) check($sformatf("joke:dst%0d", k), dst_mem[DST_BASE + k], 8'h00);
      end
      if (t == 1) begin
`ifdef PARITY_CHECK_EN
        check("joke_par:dst28", dst_mem[DST_BASE + 28], 8'h80);
`else
        check("joke_par:dst28", dst_mem[DST_BASE + 28], 8'h52 ^ 8'h04);
`endif
      end
    end

    // reset in the middle of EMIT
    setup(vecs[0]);
    launch;
    seen = 0;
    for (int c = 0; c < RUN_BUDGET && seen < 5; c++) begin
      tick;
      if (wr_en) seen++;
    end
    check("midrst:reached_5_writes", seen, 5);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    exp_q.delete();
    check("midrst:Ack", Ack, 0);
    check("midrst:wr_en", wr_en, 0);
    check("midrst:rd_addr", rd_addr, SRC_BASE);
    check("midrst:ptrn_idx", ptrn_idx, 0);
    cnt_before = wr_count;
    Start = 1'b1;
    hold_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (wr_en || rd_addr != 8'(SRC_BASE) || Ack) hold_ok = 1'b0;
    end
    check("midrst:idle_hold", hold_ok, 1);
    check("midrst:no_writes", wr_count, cnt_before);

    // a fresh run after the abort must complete normally
    run_vec(vecs[0]);
    check("rerun:dst0", dst_mem[DST_BASE], 8'h46);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
